// File: rtl/coin_pkg.sv
// Coin codes, channel indices and coin values shared by the coin acceptor and the vending FSM.
package coin_pkg;

   typedef enum logic [1:0] {
      COIN_NONE     = 2'b00,
      COIN_CIRCLE   = 2'b01,
      COIN_TRIANGLE = 2'b10,
      COIN_PENTAGON = 2'b11
   } coin_t;

   localparam int unsigned NUM_CH      = 3;
   localparam int unsigned CH_CIRCLE   = 0;
   localparam int unsigned CH_TRIANGLE = 1;
   localparam int unsigned CH_PENTAGON = 2;

   localparam int unsigned VAL_CIRCLE   = 1;
   localparam int unsigned VAL_TRIANGLE = 3;
   localparam int unsigned VAL_PENTAGON = 5;

   // Channel index n maps to coin code n+1.
   function automatic coin_t ch_to_coin(input logic [1:0] ch);
      return coin_t'(ch + 2'd1);
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-FF synchroniser, stability-counter debounce and a registered
// one-cycle pulse on each debounced rising edge.
module coin_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sense_i,
   output logic rise_o
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            rise_q, rise_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // The level flips on the edge the counter would otherwise reach DEBOUNCE_CYCLES.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == LastCnt) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sense_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin sensor front end: debounces three sensors, captures insertions as pending events,
// serialises them through a small FIFO and emits one registered coin code per coin.
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [2:0]                    sense,
   input  logic                          hold,
   input  logic                          clr_ovf,
   output logic [1:0]                    coin,
   output logic [2:0]                    pending,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic                          overflow
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [2:0]      rise;
   logic [2:0]      pend_q, pend_d, push_mask, lost;
   logic [1:0]      push_ch;
   logic            push, pop, full, empty;
   logic            ovf_q, ovf_d;
   coin_t           coin_q, coin_d;
   coin_t           mem_q [FIFO_DEPTH];
   coin_t           mem_d [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_deb
      coin_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk_i  (clock),
         .rst_ni (reset_n),
         .sense_i(sense[ch]),
         .rise_o (rise[ch])
      );
   end

   always_comb begin
      full      = (cnt_q == CntW'(FIFO_DEPTH));
      empty     = (cnt_q == '0);
      push_mask = '0;
      push_ch   = '0;
      // Fixed priority: circle > triangle > pentagon, at most one push per cycle.
      if (!full) begin
         if (pend_q[CH_CIRCLE]) begin
            push_mask[CH_CIRCLE] = 1'b1;
            push_ch              = 2'(CH_CIRCLE);
         end else if (pend_q[CH_TRIANGLE]) begin
            push_mask[CH_TRIANGLE] = 1'b1;
            push_ch                = 2'(CH_TRIANGLE);
         end else if (pend_q[CH_PENTAGON]) begin
            push_mask[CH_PENTAGON] = 1'b1;
            push_ch                = 2'(CH_PENTAGON);
         end
      end
      push = |push_mask;
      pop  = !hold && !empty;

      // A rise on a channel that is already pending is dropped.
      lost   = rise & pend_q;
      pend_d = (pend_q & ~push_mask) | (rise & ~pend_q);
      if (|lost) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = ch_to_coin(push_ch);
      end
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
      coin_d   = pop ? mem_q[rd_ptr_q] : COIN_NONE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pend_q   <= '0;
         ovf_q    <= 1'b0;
         coin_q   <= COIN_NONE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= COIN_NONE;
         end
      end else begin
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         coin_q   <= coin_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

   assign coin     = coin_q;
   assign pending  = pend_q;
   assign fifo_cnt = cnt_q;
   assign overflow = ovf_q;

endmodule
